// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: FSM state encodings and the default
// counter width that the downstream filter instantiation also uses.
package period_meter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam int DEFAULT_COUNTER_BITS = 28;

    // Period counter needs at least one bit even when a window is a single period.
    function automatic int pcnt_width(input int periods_log2);
        return (periods_log2 > 0) ? periods_log2 : 1;
    endfunction

endpackage

// File: rtl/period_meter_freq_in_sync.sv
// Brings the asynchronous oscillator into the clk domain and flags each
// rising edge with a one-cycle pulse.
module freq_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic freq_in,
    output logic synced,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], freq_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~delayed_q;

endmodule

// File: rtl/period_meter.sv
// Counts clk cycles across 2^PERIODS_LOG2 oscillator periods back to back,
// strobing each result and flagging a stuck oscillator via timeout.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNTER_BITS = DEFAULT_COUNTER_BITS,
    parameter int PERIODS_LOG2 = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    freq_in,
    output logic [COUNTER_BITS-1:0] period_value,
    output logic                    value_ce,
    output logic                    timeout
);

    localparam int                PCNT_W    = pcnt_width(PERIODS_LOG2);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'((1 << PERIODS_LOG2) - 1);

    logic                    rise;
    logic                    synced_unused;
    logic [1:0]              state;
    logic [COUNTER_BITS-1:0] cnt;
    logic [PCNT_W-1:0]       pcnt;

    freq_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .freq_in (freq_in),
        .synced  (synced_unused),
        .rise    (rise)
    );

    // NOTE: all state below is sequential, so every assignment is non-blocking;
    // value_ce defaults low each cycle so it can only ever be a single-cycle strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pcnt         <= '0;
            period_value <= '0;
            value_ce     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            value_ce <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pcnt    <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt     <= '0;
                        pcnt    <= '0;
                        timeout <= 1'b0;
                        state   <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            cnt   <= COUNTER_BITS'(1);
                            pcnt  <= '0;
                            state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        // A closing edge wins over saturation, so all-ones is a legal result.
                        if (rise && (pcnt == PCNT_LAST)) begin
                            period_value <= cnt;
                            value_ce     <= 1'b1;
                            timeout      <= 1'b0;
                            cnt          <= COUNTER_BITS'(1);
                            pcnt         <= '0;
                        end else if (cnt == '1) begin
                            timeout <= 1'b1;
                            state   <= ST_ARM;
                        end else begin
                            cnt <= cnt + COUNTER_BITS'(1);
                            if (rise) begin
                                pcnt <= pcnt + PCNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances with different
// parameters share one oscillator; each is enabled only for its own scenario.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int SYNC = 2;

    typedef struct {
        logic [31:0] value;
        int          interval;
    } exp_t;

    logic        clk = 1'b0;
    logic        freq = 1'b0;
    logic        rst_a = 1'b0, rst_bc = 1'b0;
    logic        enable_a = 1'b0, enable_b = 1'b0, enable_c = 1'b0;
    logic [27:0] period_value_a, period_value_b;
    logic [9:0]  period_value_c;
    logic        value_ce_a, value_ce_b, value_ce_c;
    logic        timeout_a, timeout_b, timeout_c;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q_a[$], q_b[$], q_c[$];
    int gap_a = 0, gap_b = 0, gap_c = 0;

    always #5 clk = ~clk;

    period_meter #(.COUNTER_BITS(28), .PERIODS_LOG2(2), .SYNC_STAGES(SYNC)) u_a (
        .clk(clk), .reset_n(rst_a), .enable(enable_a), .freq_in(freq),
        .period_value(period_value_a), .value_ce(value_ce_a), .timeout(timeout_a));

    period_meter #(.COUNTER_BITS(28), .PERIODS_LOG2(1), .SYNC_STAGES(SYNC)) u_b (
        .clk(clk), .reset_n(rst_bc), .enable(enable_b), .freq_in(freq),
        .period_value(period_value_b), .value_ce(value_ce_b), .timeout(timeout_b));

    period_meter #(.COUNTER_BITS(10), .PERIODS_LOG2(0), .SYNC_STAGES(SYNC)) u_c (
        .clk(clk), .reset_n(rst_bc), .enable(enable_c), .freq_in(freq),
        .period_value(period_value_c), .value_ce(value_ce_c), .timeout(timeout_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One oscillator period starting at a negedge: high for hi cycles, low for lo cycles.
    task automatic osc(input int hi, input int lo);
        freq = 1'b1;
        repeat (hi) @(negedge clk);
        freq = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        gap_a++;
        if (value_ce_a) begin
            if (q_a.size() == 0) check("a_unexpected_ce", 32'(value_ce_a), 32'd0);
            else begin
                e = q_a.pop_front();
                check("a_value", 32'(period_value_a), e.value);
                if (e.interval != 0) check("a_interval", gap_a, e.interval);
                check("a_timeout_on_ce", 32'(timeout_a), 32'd0);
            end
            gap_a = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        gap_b++;
        if (value_ce_b) begin
            if (q_b.size() == 0) check("b_unexpected_ce", 32'(value_ce_b), 32'd0);
            else begin
                e = q_b.pop_front();
                check("b_value", 32'(period_value_b), e.value);
                if (e.interval != 0) check("b_interval", gap_b, e.interval);
                check("b_timeout_on_ce", 32'(timeout_b), 32'd0);
            end
            gap_b = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        gap_c++;
        if (value_ce_c) begin
            if (q_c.size() == 0) check("c_unexpected_ce", 32'(value_ce_c), 32'd0);
            else begin
                e = q_c.pop_front();
                check("c_value", 32'(period_value_c), e.value);
                if (e.interval != 0) check("c_interval", gap_c, e.interval);
                check("c_timeout_on_ce", 32'(timeout_c), 32'd0);
            end
            gap_c = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;

        // Reset values while reset is held
        #12;
        check("rst_a_value", 32'(period_value_a), 32'd0);
        check("rst_a_ce", 32'(value_ce_a), 32'd0);
        check("rst_a_timeout", 32'(timeout_a), 32'd0);
        check("rst_a_state", 32'(u_a.state), 32'(ST_IDLE));
        check("rst_b_value", 32'(period_value_b), 32'd0);
        check("rst_c_value", 32'(period_value_c), 32'd0);
        check("rst_c_timeout", 32'(timeout_c), 32'd0);
        @(negedge clk);
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        repeat (3) @(negedge clk);

        // Period 100, 4-period windows: arm edge plus three full windows of 400
        enable_a = 1'b1;
        repeat (3) @(negedge clk);
        check("a_armed", 32'(u_a.state), 32'(ST_ARM));
        q_a.push_back('{400, 0});
        q_a.push_back('{400, 400});
        q_a.push_back('{400, 400});
        repeat (13) osc(50, 50);

        // Enable dropped in the very cycle the closing edge is detected
        repeat (3) osc(50, 50);
        freq = 1'b1;
        repeat (SYNC) @(negedge clk);
        enable_a = 1'b0;
        @(negedge clk);
        check("a_drop_state_idle", 32'(u_a.state), 32'(ST_IDLE));
        check("a_drop_no_ce", 32'(value_ce_a), 32'd0);
        check("a_drop_value_kept", 32'(period_value_a), 32'd400);
        repeat (50 - SYNC - 1) @(negedge clk);
        freq = 1'b0;
        repeat (50) @(negedge clk);

        // Re-enable: fresh window from the next edge
        enable_a = 1'b1;
        repeat (2) @(negedge clk);
        check("a_reenable_arm", 32'(u_a.state), 32'(ST_ARM));
        q_a.push_back('{400, 0});
        repeat (5) osc(50, 50);

        // Asynchronous reset mid-window, then a full window after release
        osc(50, 50);
        osc(50, 20);
        #3 rst_a = 1'b0;
        #1;
        check("a_rst_value", 32'(period_value_a), 32'd0);
        check("a_rst_ce", 32'(value_ce_a), 32'd0);
        check("a_rst_timeout", 32'(timeout_a), 32'd0);
        check("a_rst_state", 32'(u_a.state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b1;
        @(negedge clk);
        q_a.push_back('{400, 0});
        repeat (5) osc(50, 50);
        enable_a = 1'b0;
        repeat (5) @(negedge clk);

        // Alternating 99/101 periods, 2-period windows: every window is 200
        enable_b = 1'b1;
        repeat (3) @(negedge clk);
        q_b.push_back('{200, 0});
        q_b.push_back('{200, 200});
        q_b.push_back('{200, 200});
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) osc(50, 49);
            else            osc(50, 51);
        end
        enable_b = 1'b0;
        repeat (5) @(negedge clk);

        // Fastest legal input, single-period windows: value 2 every 2 cycles
        enable_c = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) q_c.push_back('{2, (i == 0) ? 0 : 2});
        repeat (9) osc(1, 1);

        // Oscillator stuck low: counter saturates at 1023
        freq = 1'b0;
        repeat (500) @(negedge clk);
        check("c_timeout_not_early", 32'(timeout_c), 32'd0);
        budget = 0;
        while (!timeout_c && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("c_timeout_set", 32'(timeout_c), 32'd1);
        check("c_timeout_state_arm", 32'(u_c.state), 32'(ST_ARM));
        check("c_timeout_value_kept", 32'(period_value_c), 32'd2);
        repeat (10) @(negedge clk);
        check("c_timeout_sticky", 32'(timeout_c), 32'd1);

        // Oscillator restored at period 50
        q_c.push_back('{50, 0});
        q_c.push_back('{50, 50});
        repeat (3) osc(25, 25);
        check("c_timeout_cleared", 32'(timeout_c), 32'd0);
        check("c_final_value", 32'(period_value_c), 32'd50);
        enable_c = 1'b0;
        repeat (10) @(negedge clk);

        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);
        check("c_pending", q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Front-end measurement stage of the sensor chain; its output is the raw value fed into the low-pass filter.
- Synchronises the asynchronous oscillator signal into the CLK domain and counts CLK cycles across 2^PERIODS_LOG2 oscillator periods, with no dead time between windows.
- Publishes each result with a one-cycle VALUE_CE strobe, so the filter can use it as its clock enable.
- Flags loss of oscillation (stuck input) via TIMEOUT.

Parameters:
- COUNTER_BITS, 28, width of cycle counter and PERIOD_VALUE; matches filter input width.
- PERIODS_LOG2, 4, window length = 2^PERIODS_LOG2 oscillator periods; legal range 0..8.
- SYNC_STAGES, 2, synchroniser flops on FREQ_IN; legal range 2..4.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous reset, active low.
- ENABLE  in  1  1 = measure; 0 = return to IDLE.
- FREQ_IN  in  1  asynchronous oscillator square wave.
- PERIOD_VALUE  out  COUNTER_BITS  last completed window length in CLK cycles.
- VALUE_CE  out  1  one-cycle strobe; PERIOD_VALUE updated in the same cycle.
- TIMEOUT  out  1  sticky: counter saturated; cleared on next completed window or in IDLE.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE; PERIOD_VALUE=0; VALUE_CE=0; TIMEOUT=0.
  - cycle counter cnt=0; period counter pcnt=0; synchroniser flops=0.
- Edge detect:
  - FREQ_IN passes through SYNC_STAGES flops, then one extra flop; edge = synced & ~delayed.
  - Latency from FREQ_IN rise to edge = SYNC_STAGES+1 CLK cycles.
  - At most one edge per 2 CLK cycles; faster input is undefined.
- States:
  - IDLE: cnt=0, pcnt=0, TIMEOUT=0. Go to ARM when ENABLE=1.
  - ARM: wait for an edge. On edge: cnt<=1, pcnt<=0, go to MEASURE.
  - MEASURE, no edge: cnt<=cnt+1.
  - MEASURE, edge with pcnt != 2^PERIODS_LOG2-1: pcnt<=pcnt+1, cnt<=cnt+1.
  - MEASURE, closing edge (pcnt == 2^PERIODS_LOG2-1): PERIOD_VALUE<=cnt, VALUE_CE<=1, TIMEOUT<=0, cnt<=1, pcnt<=0. Stay in MEASURE; the closing edge also starts the next window (no dead time).
  - Window value therefore equals the exact CLK-cycle distance between the window-start edge and the closing edge.
- Saturation:
  - If cnt == all-ones in MEASURE without a closing edge: TIMEOUT<=1, go to ARM.
  - PERIOD_VALUE keeps its old value; no VALUE_CE is issued.
- Simultaneous events:
  - ENABLE=0 has priority over everything. Next state is IDLE with no VALUE_CE, even if a closing edge occurs in the same cycle.
  - A closing edge in the same cycle cnt reaches all-ones counts as a valid result (all-ones is published); TIMEOUT is not set.
- VALUE_CE:
  - Registered, high for exactly one cycle.
  - Asserted 1 cycle after the closing edge is detected, i.e. SYNC_STAGES+2 cycles after the FREQ_IN rise.
- PERIODS_LOG2=0: every edge closes a window.
- Mid-operation reset returns all registers to reset values immediately. After release, the first result needs a full window after the first detected edge.

Decomposition:
- Shared package/header:
  - state encoding constants: IDLE=2'd0, ARM=2'd1, MEASURE=2'd2.
  - default COUNTER_BITS constant shared with the filter instantiation.
- One sub-module: freq_in_sync (SYNC_STAGES synchroniser + edge detector; outputs SYNCED and RISE).
- The FSM and counters stay in period_meter.

Test Plan:
- Square wave, period 100 CLK, PERIODS_LOG2=2, ENABLE held 1 -> first VALUE_CE one full window after ARM edge; PERIOD_VALUE=400; further strobes every 400 cycles, each with value 400.
- Period alternating 99/101 CLK, PERIODS_LOG2=1 -> every window =200, confirming no dead time.
- COUNTER_BITS=10, FREQ_IN stuck low after ARM edge -> TIMEOUT=1 at cnt=1023, state ARM, no VALUE_CE, PERIOD_VALUE unchanged. Then restore period 50 with PERIODS_LOG2=0 -> PERIOD_VALUE=50, TIMEOUT cleared.
- ENABLE dropped in the same cycle as a closing edge -> no VALUE_CE; state IDLE next cycle; re-enable -> ARM, fresh window.
- RESET_N pulsed low mid-window (asynchronously, between CLK edges) -> outputs 0 immediately; after release the first VALUE_CE follows a complete window.
- PERIODS_LOG2=0, period 2 CLK (fastest legal) -> PERIOD_VALUE=2 with VALUE_CE every 2 cycles.
